// File: rtl/meter_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : meter_frame_pkg
//  Description : Shared types and constants for the meter telemetry frame
//                transmitter: FSM state encoding, frame geometry, default
//                sync byte and the snapshot payload byte selector.
//  Revision    : 1.0 - initial release
// ============================================================================
package meter_frame_pkg;

    localparam int          FRAME_BYTES       = 15;
    localparam int          PAYLOAD_BYTES     = 12;
    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_SEQ     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CSUM    = 3'd4
    } state_e;

    // Snapshot in transmit order: the first field sits in the top bits so
    // payload byte 0 is the MSB of peak_l.
    typedef struct packed {
        logic [23:0] peak_l;
        logic [23:0] peak_r;
        logic [23:0] rms_l;
        logic [23:0] rms_r;
    } snap_t;

    // Payload byte 'idx' (0..11) of a snapshot, MSB-first per field.
    function automatic byte_t payload_byte(input snap_t snap, input logic [3:0] idx);
        logic [95:0] flat;
        int          sh;
        flat = snap;
        sh   = 8 * (PAYLOAD_BYTES - 1 - int'(idx));
        return 8'(flat >> sh);
    endfunction

endpackage
`default_nettype wire

// File: rtl/meter_frame_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : meter_frame_tx_if
//  Description : Byte-wide valid/ready stream carrying telemetry frames.
//                master: tx_data/tx_valid out, tx_ready in.
//                slave : tx_data/tx_valid in,  tx_ready out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface meter_frame_tx_if;
    import meter_frame_pkg::*;

    byte_t tx_data;
    logic  tx_valid;
    logic  tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/meter_frame_timer.sv
`default_nettype none
// ============================================================================
//  Module      : meter_frame_timer
//  Description : Periodic snapshot tick generator. Counts while en is high,
//                pulses tick for one cycle when the count reaches
//                PERIOD_CYCLES-1 and wraps; held at zero while en is low.
//  Ports       : clk, rst (async, active high), en in; tick out.
//  Revision    : 1.0 - initial release
// ============================================================================
module meter_frame_timer #(
    parameter int unsigned PERIOD_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int                CNT_W    = $clog2(PERIOD_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERIOD_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && (cnt_q == CNT_LAST);
        cnt_d = cnt_q + 1'b1;
        if (!en || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/meter_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : meter_frame_tx
//  Description : Meter telemetry transmitter. On a periodic tick or a
//                snap_req it latches the four 24-bit meter values and sends
//                a 15-byte frame: SYNC, seq, 12 payload bytes, CSUM.
//  Ports       : clk, rst (async, active high)
//                en        - enables periodic ticks
//                snap_req  - single-cycle snapshot request
//                peak_l/peak_r/rms_l/rms_r - meter values (24 bit)
//                tx        - byte stream (master modport)
//                busy      - frame in progress
//                seq       - sequence number of next/current frame
//                drop_cnt  - saturating count of discarded triggers
//  Revision    : 1.0 - initial release
// ============================================================================
module meter_frame_tx
    import meter_frame_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES = 1024,
    parameter logic [7:0]  SYNC_BYTE     = DEFAULT_SYNC_BYTE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    snap_req,
    input  logic [23:0]             peak_l,
    input  logic [23:0]             peak_r,
    input  logic [23:0]             rms_l,
    input  logic [23:0]             rms_r,
    meter_frame_tx_if.master        tx,
    output logic                    busy,
    output logic [7:0]              seq,
    output logic [7:0]              drop_cnt
);
    localparam logic [3:0] LAST_IDX = 4'(PAYLOAD_BYTES - 1);

    logic   tick;
    logic   trig;
    logic   hs;
    logic   last_hs;
    logic   launch;

    state_e state_q, state_d;
    logic [3:0] idx_q, idx_d;
    snap_t  snap_q, snap_d;
    byte_t  csum_q, csum_d;
    logic   pend_q, pend_d;
    byte_t  seq_q, seq_d;
    byte_t  drop_q, drop_d;
    byte_t  data_q, data_d;
    logic   valid_q, valid_d;

    meter_frame_timer #(
        .PERIOD_CYCLES(PERIOD_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        csum_d  = csum_q;
        pend_d  = pend_q;
        seq_d   = seq_q;
        drop_d  = drop_q;
        data_d  = data_q;
        valid_d = valid_q;

        trig    = snap_req || tick;
        hs      = valid_q && tx.tx_ready;
        last_hs = (state_q == ST_CSUM) && hs;
        launch  = 1'b0;

        // The next byte is loaded into data_q on the handshake of the current
        // one, so tx_data only moves when the sink has taken the byte.
        // The running sum covers seq and payload; it is folded in per
        // handshake, so its value is independent of tx_ready timing.
        unique case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    launch = 1'b1;
                end
            end
            ST_SYNC: begin
                if (hs) begin
                    state_d = ST_SEQ;
                    data_d  = seq_q;
                end
            end
            ST_SEQ: begin
                if (hs) begin
                    state_d = ST_PAYLOAD;
                    idx_d   = 4'd0;
                    csum_d  = csum_q + data_q;
                    data_d  = payload_byte(snap_q, 4'd0);
                end
            end
            ST_PAYLOAD: begin
                if (hs) begin
                    csum_d = csum_q + data_q;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_CSUM;
                        data_d  = 8'd0 - (csum_q + data_q);
                    end else begin
                        idx_d  = idx_q + 4'd1;
                        data_d = payload_byte(snap_q, idx_q + 4'd1);
                    end
                end
            end
            ST_CSUM: begin
                if (hs) begin
                    seq_d  = seq_q + 8'd1;
                    pend_d = 1'b0;
                    if (pend_q || trig) begin
                        // Back-to-back frame with a fresh snapshot.
                        launch = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase

        // A trigger arriving mid-frame is queued once; further ones are
        // counted as dropped. A trigger on the final handshake with nothing
        // pending launches directly above instead of being queued.
        if (trig && (state_q != ST_IDLE)) begin
            if (pend_q) begin
                drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
            end else if (!last_hs) begin
                pend_d = 1'b1;
            end
        end

        if (launch) begin
            snap_d  = '{peak_l: peak_l, peak_r: peak_r, rms_l: rms_l, rms_r: rms_r};
            csum_d  = 8'd0;
            state_d = ST_SYNC;
            data_d  = SYNC_BYTE;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            snap_q  <= '0;
            csum_q  <= 8'd0;
            pend_q  <= 1'b0;
            seq_q   <= 8'd0;
            drop_q  <= 8'd0;
            data_q  <= 8'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            csum_q  <= csum_d;
            pend_q  <= pend_d;
            seq_q   <= seq_d;
            drop_q  <= drop_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign tx.tx_data  = data_q;
    assign tx.tx_valid = valid_q;
    assign busy        = (state_q != ST_IDLE);
    assign seq         = seq_q;
    assign drop_cnt    = drop_q;

endmodule
`default_nettype wire
